// File: rtl/mem_request_master_if.sv
// Client request/response and memory-side signals of mem_request_master.
// The master modport is the block's view; slave is the client/memory view.
interface mem_request_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic [3:0]  req_len;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_last;
  logic        wr_done;
  logic        busy;
  logic [23:0] RAMaddress;
  logic        write_enable;
  logic [15:0] write_data;
  logic [15:0] RAMdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_len, RAMdata,
    output req_ready, resp_valid, resp_rdata, resp_last, wr_done, busy,
           RAMaddress, write_enable, write_data
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_len, RAMdata,
    input  req_ready, resp_valid, resp_rdata, resp_last, wr_done, busy,
           RAMaddress, write_enable, write_data
  );
endinterface

// File: rtl/mem_request_master.sv
// Request master: single-word writes and incrementing read bursts to a
// fixed-latency memory controller, with in-order response tagging.
//
// state | meaning
// IDLE  | ready for a new request
// WRITE | write strobe issued for the captured word
// READ  | issuing burst addresses, one per cycle
// DRAIN | all addresses issued, waiting for the last response
module mem_request_master #(
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_request_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                  state, state_next;
  logic [3:0]              cnt;
  logic [23:0]             ram_address;
  logic [15:0]             wdata_q;
  logic [15:0]             rdata_hold;
  logic                    wr_done_q;
  logic [READ_LATENCY-1:0] tag_valid;
  logic [READ_LATENCY-1:0] tag_last;
  logic                    accept;
  logic                    issue;
  logic                    issue_last;
  logic                    resp_valid_i;
  logic                    resp_last_i;

  assign accept       = bus.req_valid & bus.req_ready;
  assign issue        = (state == READ);
  assign issue_last   = issue & (cnt == 4'd0);
  assign resp_valid_i = tag_valid[READ_LATENCY-1];
  assign resp_last_i  = tag_last[READ_LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = bus.req_write ? WRITE : READ;
      WRITE:   state_next = IDLE;
      READ:    if (cnt == 4'd0) state_next = DRAIN;
      DRAIN:   if (resp_valid_i && resp_last_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured only at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_address <= '0;
      wdata_q     <= '0;
      cnt         <= '0;
    end else if (accept) begin
      ram_address <= bus.req_addr;
      cnt         <= bus.req_len;
      if (bus.req_write) wdata_q <= bus.req_wdata;
    end else if (issue && cnt != 4'd0) begin
      ram_address <= ram_address + 24'd1;
      cnt         <= cnt - 4'd1;
    end
  end

  // Tag pipeline mirrors the memory latency so each word lines up with its data.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid <= '0;
      tag_last  <= '0;
      wr_done_q <= 1'b0;
    end else begin
      tag_valid[0] <= issue;
      tag_last[0]  <= issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_last[i]  <= tag_last[i-1];
      end
      wr_done_q <= (state == WRITE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)             rdata_hold <= '0;
    else if (resp_valid_i) rdata_hold <= bus.RAMdata;
  end

  assign bus.req_ready    = (state == IDLE) && !reset;
  assign bus.busy         = (state != IDLE);
  assign bus.write_enable = (state == WRITE);
  assign bus.RAMaddress   = ram_address;
  assign bus.write_data   = wdata_q;
  assign bus.wr_done      = wr_done_q;
  assign bus.resp_valid   = resp_valid_i;
  assign bus.resp_last    = resp_valid_i & resp_last_i;
  assign bus.resp_rdata   = resp_valid_i ? bus.RAMdata : rdata_hold;

endmodule
